// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with run-time almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and registered read data with a valid strobe.
module fifo_sync_param #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   almost_full_thr,
  input  logic [ADDR_WIDTH:0]   almost_empty_thr,
  input  logic                  error_clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full_fifo,
  output logic                  empty_fifo,
  output logic                  almost_full_fifo,
  output logic                  almost_empty_fifo,
  output logic                  overflow_error,
  output logic                  underflow_error,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  rd_acc;
  logic                  wr_acc;

  // A read accepted in the same cycle frees a slot, so a full FIFO still takes the write.
  assign rd_acc = rd_enable & ~empty_fifo;
  assign wr_acc = wr_enable & (~full_fifo | rd_acc);

  assign full_fifo         = (count == DEPTH_CNT);
  assign empty_fifo        = (count == '0);
  assign almost_full_fifo  = (count >= almost_full_thr);
  assign almost_empty_fifo = (count <= almost_empty_thr);
  assign fill_level        = count;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A rejected request sets its flag even if error_clear is asserted in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if (wr_enable & ~wr_acc) begin
        overflow_error <= 1'b1;
      end else if (error_clear) begin
        overflow_error <= 1'b0;
      end
      if (rd_enable & ~rd_acc) begin
        underflow_error <= 1'b1;
      end else if (error_clear) begin
        underflow_error <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, the next generation of the team's single-clock buffer. Width and depth are set by parameters. The almost-full and almost-empty thresholds are set at run time through ports. Writes on a full FIFO and reads on an empty FIFO are blocked, and each sets its own sticky error flag. Read data is registered and comes with a valid strobe. The block sits between the packet producer and consumer stages of the datapath as the standard per-lane buffer.

## Interface
- DATA_WIDTH, 10, width of each data word
- ADDR_WIDTH, 3, pointer width; depth DEPTH = 2**ADDR_WIDTH (8 by default)
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- wr_enable  input  1  write request
- rd_enable  input  1  read request
- data_in  input  DATA_WIDTH  write data
- almost_full_thr  input  ADDR_WIDTH+1  almost-full threshold, in words
- almost_empty_thr  input  ADDR_WIDTH+1  almost-empty threshold, in words
- error_clear  input  1  clears both sticky error flags
- data_out  output  DATA_WIDTH  registered read data
- valid_out  output  1  data_out was updated by a read accepted in the previous cycle
- full_fifo  output  1  count == DEPTH
- empty_fifo  output  1  count == 0
- almost_full_fifo  output  1  count >= almost_full_thr
- almost_empty_fifo  output  1  count <= almost_empty_thr
- overflow_error  output  1  sticky; set by a write rejected because the FIFO was full
- underflow_error  output  1  sticky; set by a read rejected because the FIFO was empty
- fill_level  output  ADDR_WIDTH+1  current count

## Operation
- **State:** memory of DEPTH x DATA_WIDTH; wr_ptr and rd_ptr, ADDR_WIDTH bits each; count, ADDR_WIDTH+1 bits.
- **Reset** (reset=1 at a rising edge of clk):
  - wr_ptr, rd_ptr, count = 0.
  - data_out = 0, valid_out = 0.
  - overflow_error = 0, underflow_error = 0.
  - Memory contents are not reset.
  - Reset has priority over all other inputs, including mid-stream traffic.
- **Read accept:** rd_acc = rd_enable & ~empty_fifo.
- **Write accept:** wr_acc = wr_enable & (~full_fifo | rd_acc).
  - When full, a simultaneous accepted read frees a slot, so the write is accepted.
- **On wr_acc:** mem[wr_ptr] <= data_in; wr_ptr increments.
- **On rd_acc:** data_out <= mem[rd_ptr]; rd_ptr increments; valid_out <= 1.
- **Otherwise:** valid_out <= 0 and data_out holds its value.
- **Count update:**
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - count never exceeds DEPTH and never goes below 0.
- **Pointer wrap:** both pointers wrap naturally modulo DEPTH (DEPTH-1 -> 0); there is no special case.
- **Empty with rd_enable & wr_enable together:**
  - The write is accepted and the read is rejected.
  - underflow_error is set.
  - count becomes 1.
- **Full with wr_enable only:**
  - The write is dropped; memory and pointers are unchanged.
  - overflow_error is set.
- **Sticky errors:**
  - An error is set on any rejected request.
  - It is cleared by error_clear=1.
  - Set wins over clear in the same cycle.
- **Flags:** all flags and fill_level are combinational decodes of the registered count.
  - Thresholds are compared unsigned and may change at any time; flags follow in the same cycle.
  - almost_full_thr=0 makes almost_full_fifo constantly 1.
  - Threshold values above DEPTH are legal: almost_full_fifo is then never asserted, and almost_empty_fifo is always asserted.

## Timing
- **Write to empty deassert:** a write accepted at edge N makes empty_fifo=0 after edge N. A read issued in the cycle before edge N+1 is accepted.
- **Read latency:** one cycle. A read accepted at edge N presents data_out and valid_out=1 after edge N, held until edge N+1.
- **Back-to-back reads:** one read per cycle gives one valid word per cycle.
- **Full throughput:** one write plus one read per cycle is sustained at any count, with the exceptions above.
- **Flag update:** all flags update one edge after the accepted operation that changes count.

## Test plan
- **Reset:** assert reset mid-burst with count=5 -> after the next edge count=0, empty_fifo=1, data_out=0, valid_out=0, both error flags 0.
- **Fill and drain:**
  - Stimulus: 8 writes of 0x001..0x008, then 8 reads.
  - After the writes: full_fifo=1 and fill_level=8.
  - Reads return 0x001..0x008 in order, with valid_out high for each.
  - After the reads: empty_fifo=1.
- **Overflow:**
  - Stimulus: when full, write 0x3FF alone.
  - overflow_error=1, count stays 8, and the drain contains no 0x3FF.
  - error_clear=1 -> overflow_error=0 on the next edge.
- **Simultaneous access at the limits:**
  - Full, write 0x055 and read together: the oldest word is output, count stays 8, and 0x055 is read last.
  - Empty, write and read together: count=1, underflow_error=1, valid_out=0.
- **Wrap-around:** 20 cycles of interleaved single writes and reads at count 3-4 -> every word read matches the write order across two pointer wraps.
- **Thresholds:**
  - Settings: almost_full_thr=6, almost_empty_thr=2.
  - Filling: almost_empty_fifo drops when count goes 2->3, and almost_full_fifo rises when count goes 5->6.
  - Changing almost_full_thr to 7 at count 6 -> almost_full_fifo falls in the same cycle.
